// File: rtl/fewcore_pkg.sv
// fewcore shared definitions: opcodes, forward encodings,
// hazard FSM state, ID decode bundle and EX tracking slot.
package fewcore_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_RS2  = 2'b01;
  localparam logic [1:0] FWD_RS1  = 2'b10;
  localparam logic [1:0] FWD_BOTH = 2'b11;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic use1;
    logic use2;
    logic wr;
    logic is_store;
    logic is_load;
    logic is_branch;
    logic is_jump;
  } dec_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
    logic       is_branch;
    logic       is_jump;
  } slot_t;

  function automatic dec_t decode(
    input logic [6:0] opc
  );
    dec_t d;
    d = '0;
    unique case (1'b1)
      (opc == OP_R): begin
        d.use1 = 1'b1;
        d.use2 = 1'b1;
        d.wr   = 1'b1;
      end
      (opc == OP_IMM): begin
        d.use1 = 1'b1;
        d.wr   = 1'b1;
      end
      (opc == OP_LOAD): begin
        d.use1    = 1'b1;
        d.wr      = 1'b1;
        d.is_load = 1'b1;
      end
      (opc == OP_STORE): begin
        d.use1     = 1'b1;
        d.use2     = 1'b1;
        d.is_store = 1'b1;
      end
      (opc == OP_BRANCH): begin
        d.use1      = 1'b1;
        d.use2      = 1'b1;
        d.is_branch = 1'b1;
      end
      (opc == OP_JAL): begin
        d.wr      = 1'b1;
        d.is_jump = 1'b1;
      end
      (opc == OP_JALR): begin
        d.use1    = 1'b1;
        d.wr      = 1'b1;
        d.is_jump = 1'b1;
      end
      (opc == OP_LUI),
      (opc == OP_AUIPC): begin
        d.wr = 1'b1;
      end
      default: begin
        d = '0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination compare against one tracking slot.
// Only valid slots with a real (non-x0) destination match.
module hazard_cmp (
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rd,
  input  logic       i_valid,
  output logic       o_match
);

  assign o_match = i_valid
                && (i_rd != 5'd0)
                && (i_rs == i_rd);

endmodule

// File: rtl/hazard_ctrl.sv
// ID->EX issue/hazard control: stall, forward select, squash.
// HAZARD_FWD_EN enables forwarding; otherwise any s1 hit stalls.
module hazard_ctrl
  import fewcore_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int OPC_W        = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             alu_zero,
  output logic             id_ready,
  output logic             ex_valid,
  output logic [1:0]       need_forward,
  output logic             flush
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;

  slot_t       r_s1;
  slot_t       w_s1_nx;
  logic        r_s2_valid;
  logic [4:0]  r_s2_rd;
  logic        r_ex_valid;

  logic [6:0]  w_opc;
  dec_t        w_dec;
  logic        w_rs1_s1;
  logic        w_rs2_s1;
  logic        w_rs1_s2;
  logic        w_rs2_s2;
  logic        w_f1;
  logic        w_f2;
  logic        w_s1_stall;
  logic        w_hazard;
  logic        w_redirect;
  logic        w_squash;
  logic        w_issue;

  assign w_opc = 7'(id_opcode);
  assign w_dec = decode(w_opc);

  hazard_cmp u_rs1_s1 (
    .i_rs    (id_rs1),
    .i_rd    (r_s1.rd),
    .i_valid (r_s1.valid),
    .o_match (w_rs1_s1)
  );

  hazard_cmp u_rs2_s1 (
    .i_rs    (id_rs2),
    .i_rd    (r_s1.rd),
    .i_valid (r_s1.valid),
    .o_match (w_rs2_s1)
  );

  hazard_cmp u_rs1_s2 (
    .i_rs    (id_rs1),
    .i_rd    (r_s2_rd),
    .i_valid (r_s2_valid),
    .o_match (w_rs1_s2)
  );

  hazard_cmp u_rs2_s2 (
    .i_rs    (id_rs2),
    .i_rd    (r_s2_rd),
    .i_valid (r_s2_valid),
    .o_match (w_rs2_s2)
  );

  assign w_f1 = w_dec.use1 && w_rs1_s1;
  assign w_f2 = w_dec.use2 && w_rs2_s1;

`ifdef HAZARD_FWD_EN
  assign w_s1_stall = ((w_f1 || w_f2) && r_s1.is_load)
                   || (w_dec.is_store && w_f2);
`else
  assign w_s1_stall = w_f1 || w_f2;
`endif

  assign w_hazard = (w_dec.use1 && w_rs1_s2)
                 || (w_dec.use2 && w_rs2_s2)
                 || w_s1_stall;

  assign w_redirect = (r_state == ST_RUN)
                   && r_s1.valid
                   && (r_s1.is_jump
                       || (r_s1.is_branch && alu_zero));

  assign w_squash = w_redirect || (r_state == ST_FLUSH);
  assign w_issue  = id_valid && !w_squash && !w_hazard;

  assign id_ready = !(id_valid && !w_squash && w_hazard);
  assign flush    = w_squash;
  assign ex_valid = r_ex_valid;

  // Next EX slot: decoded ID instruction, or a bubble.
  always_comb begin
    w_s1_nx           = '0;
    w_s1_nx.valid     = w_issue;
    w_s1_nx.rd        = (w_issue && w_dec.wr) ? id_rd : 5'd0;
    w_s1_nx.is_load   = w_issue && w_dec.is_load;
    w_s1_nx.is_branch = w_issue && w_dec.is_branch;
    w_s1_nx.is_jump   = w_issue && w_dec.is_jump;
  end

  // Squash FSM: trigger cycle plus FLUSH_CYCLES-1 in FLUSH.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (w_redirect && (FLUSH_CYCLES > 1)) begin
          w_state_nx = ST_FLUSH;
          w_cnt_nx   = CW'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (r_cnt <= CW'(1)) begin
          w_state_nx = ST_RUN;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nx = ST_RUN;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // FSM state and flush counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Slot shift and EX valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_rd    <= 5'd0;
      r_ex_valid <= 1'b0;
    end else begin
      r_s1       <= w_s1_nx;
      r_s2_valid <= r_s1.valid;
      r_s2_rd    <= r_s1.rd;
      r_ex_valid <= w_issue;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] r_nf;
  logic [1:0] w_nf;

  // Forward select for the issuing instruction.
  always_comb begin
    w_nf = FWD_NONE;
    unique case ({w_f1, w_f2})
      2'b11:   w_nf = FWD_BOTH;
      2'b10:   w_nf = FWD_RS1;
      2'b01:   w_nf = FWD_RS2;
      default: w_nf = FWD_NONE;
    endcase
  end

  // Forward select travels with the instruction into EX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nf <= FWD_NONE;
    end else begin
      r_nf <= w_issue ? w_nf : FWD_NONE;
    end
  end

  assign need_forward = r_nf;
`else
  assign need_forward = FWD_NONE;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios
// plus randomized traffic against a per-cycle issue model.
module tb_hazard_ctrl;

  localparam int FC = 2;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] OR_ = 7'b0110011;
  localparam logic [6:0] OI  = 7'b0010011;
  localparam logic [6:0] OL  = 7'b0000011;
  localparam logic [6:0] OS  = 7'b0100011;
  localparam logic [6:0] OB  = 7'b1100011;
  localparam logic [6:0] OJ  = 7'b1101111;
  localparam logic [6:0] OJR = 7'b1100111;
  localparam logic [6:0] OU  = 7'b0110111;
  localparam logic [6:0] OA  = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [6:0] id_opcode = 7'd0;
  logic [4:0] id_rs1 = 5'd0;
  logic [4:0] id_rs2 = 5'd0;
  logic [4:0] id_rd = 5'd0;
  logic       alu_zero = 1'b0;
  logic       id_ready;
  logic       ex_valid;
  logic [1:0] need_forward;
  logic       flush;

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] obs;
  logic [4:0] exp_m;

  // model: issue history, newest first, and squash cycles left
  bit         pv [2];
  logic [4:0] pdst [2];
  bit         pld, pbr, pjmp;
  int         sq;

  hazard_ctrl #(
    .FLUSH_CYCLES (FC),
    .OPC_W        (7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .alu_zero     (alu_zero),
    .id_ready     (id_ready),
    .ex_valid     (ex_valid),
    .need_forward (need_forward),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    pv[0] = 0; pv[1] = 0;
    pdst[0] = 0; pdst[1] = 0;
    pld = 0; pbr = 0; pjmp = 0;
    sq = 0;
  endtask

  function automatic bit hit(input int k, input logic [4:0] r);
    return pv[k] && (r != 5'd0) && (pdst[k] == r);
  endfunction

  task automatic model_step();
    bit r1, r2, w, st, ld, br, jp, squash, stall, iss;
    logic [1:0] fw;
    r1 = id_opcode inside {OR_, OB, OI, OL, OJR, OS};
    r2 = id_opcode inside {OR_, OB, OS};
    w  = id_opcode inside {OR_, OI, OL, OJ, OJR, OU, OA};
    st = (id_opcode == OS);
    ld = (id_opcode == OL);
    br = (id_opcode == OB);
    jp = id_opcode inside {OJ, OJR};
    squash = 0;
    if (sq > 0) begin
      squash = 1;
      sq--;
    end else if (pv[0] && (pjmp || (pbr && alu_zero))) begin
      squash = 1;
      sq = FC - 1;
    end
    stall = 0;
    fw = 2'b00;
    if (r1) begin
      if (hit(1, id_rs1)) stall = 1;
      else if (hit(0, id_rs1)) begin
        if (pld || !FWD) stall = 1;
        else fw[1] = 1;
      end
    end
    if (r2) begin
      if (hit(1, id_rs2)) stall = 1;
      else if (hit(0, id_rs2)) begin
        if (pld || !FWD || st) stall = 1;
        else fw[0] = 1;
      end
    end
    iss = id_valid && !squash && !stall;
    exp_m = {!(id_valid && !squash && stall), squash,
             iss, iss ? fw : 2'b00};
    pv[1] = pv[0];
    pdst[1] = pdst[0];
    pv[0] = iss;
    pdst[0] = (iss && w) ? id_rd : 5'd0;
    pld = iss && ld;
    pbr = iss && br;
    pjmp = iss && jp;
  endtask

  // one pipeline cycle; obs = {id_ready, flush, ex_valid, need_forward}
  task automatic cyc(input logic v, input logic [6:0] op,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic z);
    logic rdy, fl;
    id_valid = v; id_opcode = op;
    id_rs1 = a; id_rs2 = b; id_rd = d;
    alu_zero = z;
    #2;
    rdy = id_ready;
    fl = flush;
    model_step();
    @(posedge clk);
    #1;
    obs = {rdy, fl, ex_valid, need_forward};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 7'd0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {id_ready, flush, ex_valid, need_forward};
    n_chk++;
    if (obs !== 5'b10000) begin
      n_err++;
      $display("FAIL reset got %b want 10000", obs);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_forward();
    logic [4:0] e [4];
    cyc(1, OR_, 1, 2, 5, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL fwd_add got %b want 10100", obs);
    end
`ifdef HAZARD_FWD_EN
    e = '{5'b10111, 5'b0, 5'b0, 5'b0};
    cyc(1, OR_, 5, 5, 6, 0);
    n_chk++;
    if (obs !== e[0]) begin
      n_err++;
      $display("FAIL fwd_sub got %b want %b", obs, e[0]);
    end
`else
    e = '{5'b00000, 5'b00000, 5'b10100, 5'b0};
    for (int i = 0; i < 3; i++) begin
      cyc(1, OR_, 5, 5, 6, 0);
      n_chk++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL fwd_sub c%0d got %b want %b", i, obs, e[i]);
      end
    end
`endif
    idle(2);
  endtask

  task automatic test_load_use();
    logic [4:0] e [3];
    e = '{5'b00000, 5'b00000, 5'b10100};
    cyc(1, OL, 1, 0, 5, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL lu_lw got %b want 10100", obs);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, OI, 5, 0, 6, 0);
      n_chk++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL lu_addi c%0d got %b want %b", i, obs, e[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_distance();
    logic [4:0] e [3];
    cyc(1, OR_, 1, 2, 5, 0);
    cyc(1, OR_, 3, 4, 7, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL d2_or got %b want 10100", obs);
    end
    e = '{5'b00000, 5'b10100, 5'b0};
    for (int i = 0; i < 2; i++) begin
      cyc(1, OR_, 1, 5, 8, 0);
      n_chk++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL d2_use c%0d got %b want %b", i, obs, e[i]);
      end
    end
    idle(2);
    cyc(1, OR_, 1, 2, 5, 0);
`ifdef HAZARD_FWD_EN
    cyc(1, OR_, 1, 5, 8, 0);
    n_chk++;
    if (obs !== 5'b10101) begin
      n_err++;
      $display("FAIL d1_use got %b want 10101", obs);
    end
`else
    e = '{5'b00000, 5'b00000, 5'b10100};
    for (int i = 0; i < 3; i++) begin
      cyc(1, OR_, 1, 5, 8, 0);
      n_chk++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL d1_use c%0d got %b want %b", i, obs, e[i]);
      end
    end
`endif
    idle(2);
  endtask

  task automatic test_branch();
    cyc(1, OR_, 1, 2, 5, 0);
    cyc(1, OB, 1, 2, 0, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL br_issue got %b want 10100", obs);
    end
    cyc(1, OR_, 1, 5, 6, 1);
    n_chk++;
    if (obs !== 5'b11000) begin
      n_err++;
      $display("FAIL br_trig got %b want 11000", obs);
    end
    cyc(1, OR_, 1, 2, 7, 1);
    n_chk++;
    if (obs !== 5'b11000) begin
      n_err++;
      $display("FAIL br_flush got %b want 11000", obs);
    end
    cyc(1, OR_, 1, 2, 9, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL br_after got %b want 10100", obs);
    end
    idle(2);
    cyc(1, OB, 1, 2, 0, 0);
    cyc(1, OR_, 1, 2, 6, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL br_nt got %b want 10100", obs);
    end
    idle(2);
  endtask

  task automatic test_jal();
    cyc(1, OJ, 0, 0, 1, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL jal_issue got %b want 10100", obs);
    end
    for (int i = 0; i < FC; i++) begin
      cyc(1, OR_, 3, 4, 2, 0);
      n_chk++;
      if (obs !== 5'b11000) begin
        n_err++;
        $display("FAIL jal_flush c%0d got %b want 11000", i, obs);
      end
    end
    cyc(1, OR_, 3, 4, 2, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL jal_after got %b want 10100", obs);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_flush();
    logic [4:0] e [3];
    cyc(1, OJ, 0, 0, 1, 0);
    cyc(1, OR_, 3, 4, 2, 0);
    id_valid = 1'b0;
    #2;
    n_chk++;
    if (flush !== 1'b1) begin
      n_err++;
      $display("FAIL rmf_pre flush got %b want 1", flush);
    end
    reset = 1'b0;
    #1;
    obs = {id_ready, flush, ex_valid, need_forward};
    n_chk++;
    if (obs !== 5'b10000) begin
      n_err++;
      $display("FAIL rmf_rst got %b want 10000", obs);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    cyc(1, OR_, 0, 0, 5, 0);
    n_chk++;
    if (obs !== 5'b10100) begin
      n_err++;
      $display("FAIL rmf_add5 got %b want 10100", obs);
    end
`ifdef HAZARD_FWD_EN
    cyc(1, OR_, 5, 0, 6, 0);
    n_chk++;
    if (obs !== 5'b10110) begin
      n_err++;
      $display("FAIL rmf_add6 got %b want 10110", obs);
    end
`else
    e = '{5'b00000, 5'b00000, 5'b10100};
    for (int i = 0; i < 3; i++) begin
      cyc(1, OR_, 5, 0, 6, 0);
      n_chk++;
      if (obs !== e[i]) begin
        n_err++;
        $display("FAIL rmf_add6 c%0d got %b want %b", i, obs, e[i]);
      end
    end
`endif
    idle(2);
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [6:0] op;
    int         held;
    ops = '{OR_, OI, OL, OS, OB, OJ, OJR, OU, OA, 7'h00};
    held = 0;
    op = OR_;
    for (int i = 0; i < 800; i++) begin
      logic v;
      logic [4:0] a, b, d;
      v = ($urandom_range(0, 9) < 8);
      op = ops[$urandom_range(0, 9)];
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      d = 5'($urandom_range(0, 3));
      cyc(v, op, a, b, d, 1'($urandom_range(0, 1)));
      n_chk++;
      if (obs !== exp_m) begin
        n_err++;
        $display("FAIL rand c%0d op=%b got %b want %b",
                 i, op, obs, exp_m);
      end
      if (obs[2]) held++;
    end
    n_chk++;
    if (held == 0) begin
      n_err++;
      $display("FAIL rand_issue got 0 issues want >0");
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_load_use();
    test_distance();
    test_branch();
    test_jal();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Issue/hazard controller sitting at the ID→EX boundary of the fewcore pipeline, in front of the `alu` block. Tracks destination registers of the last two issued instructions and registers `need_forward` for the ALU's single forward bus. Stalls ID when forwarding cannot resolve a hazard. Squashes wrong-path instructions after taken branches and jumps.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2: cycles of squash after a redirect (≥1).
- `OPC_W`, 7: opcode width.

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-low reset
- `id_valid`  in  1  ID holds an instruction
- `id_opcode`  in  7  opcode of the ID instruction
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register fields of the ID instruction
- `alu_zero`  in  1  ALU `zero`, branch outcome of the instruction issued last cycle
- `id_ready`  out  1  ID instruction is consumed this cycle
- `ex_valid`  out  1  registered; EX holds a real instruction (0 = bubble)
- `need_forward`  out  2  registered; [1]=rs1 from forward, [0]=rs2 from forward
- `flush`  out  1  squash IF/ID this cycle

## Operation
- Usage decode from `id_opcode`:
  - R, B read rs1 and rs2.
  - I-arith, load, JALR read rs1.
  - S reads rs1 (ALU) and rs2 (store data).
  - LUI, AUIPC, JAL read none.
  - rd is written by R, I-arith, load, JAL, JALR, LUI, AUIPC.
  - rd=x0 is never a producer.
- Tracking slots: `s1` = instruction in EX, `s2` = one older. Each holds {valid, rd, is_load, is_branch, is_jump}. Bubbles enter as invalid. Slots shift every cycle: s2←s1, s1←issued or bubble.
- Match rules, per source used:
  - Match s2 → stall.
  - Match s1 and s1 is a load → stall.
  - S-type rs2 match s1 → stall (store data does not use the forward bus).
  - Other match s1 → set the corresponding `need_forward` bit.
  - rs1==rs2 both matching s1 → `2'b11`.
- Stall: `id_ready`=0; bubble issued (`ex_valid`=0, `need_forward`=00).
- Load-use therefore costs exactly 2 bubbles. Distance-2 use costs 1 bubble.
- FSM states:
  - RUN → FLUSH when s1 is_jump, or when s1 is_branch && `alu_zero`.
  - FLUSH: a counter counts `FLUSH_CYCLES` cycles, including the trigger cycle, then returns to RUN.
- Squash behaviour, in the trigger cycle and throughout FLUSH:
  - `flush`=1, `id_ready`=1 (wrong-path instruction drained).
  - Bubble issued.
  - No hazard check.
- `alu_zero` is ignored unless s1 is_branch.

## Timing
- Reset values: `ex_valid`=0, `need_forward`=00, state RUN, slots invalid.
- While reset is low: `id_ready`=1, `flush`=0.
- `ex_valid` and `need_forward` are registered. They change on the posedge that moves the instruction into EX, aligned with the operands reaching the ALU.
- `id_ready` and `flush` are combinational from ID fields, slots, state and `alu_zero`.
- Forwarded value is the ALU's registered output of the instruction issued the previous cycle. Latency ID→EX is 1 cycle when there is no hazard.
- Simultaneous redirect and stall: flush wins, and the stalled instruction is discarded.
- A redirect during FLUSH is impossible (slots hold bubbles).
- `id_valid`=0: bubble issued, `id_ready`=1.
- Reset mid-flush: returns to RUN with all slots cleared.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- Undefined: `need_forward` is tied to 00, and any s1 match stalls.
  - Distance-1 use costs 2 bubbles, the same as load-use.

## Structure
- Shared package `fewcore_pkg` holds:
  - Opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
  - `need_forward` encodings: FWD_NONE, FWD_RS2, FWD_RS1, FWD_BOTH.
  - FSM state type.
- One sub-module `hazard_cmp`, instantiated four times (rs1/rs2 × s1/s2): 5-bit equality qualified by slot valid and rd≠0.

## Test plan
- `add x5,x1,x2` then `sub x6,x5,x5`: no stall, sub issues with `need_forward`=11, `ex_valid`=1 both cycles.
- `lw x5,0(x1)` then `addi x6,x5,1`: `id_ready`=0 for 2 cycles, 2 bubbles, then addi issues with `need_forward`=00.
- `add x5,..`, unrelated `or x7,..`, then `add x8,x1,x5`: one bubble before the third instruction. With `HAZARD_FWD_EN` undefined, `add x5` followed directly by `add x8,x1,x5` gives 2 bubbles.
- `beq` issued, `alu_zero`=1 next cycle: `flush`=1 for 2 cycles, 2 bubbles, and the younger stalled instruction is dropped. With `alu_zero`=0: no flush.
- `jal x1,..`: flush for `FLUSH_CYCLES` cycles starting the cycle after issue.
- Reset low mid-FLUSH: `ex_valid`=0, `need_forward`=00, `flush`=0 immediately. After release, `add x5,x0,x0` then `add x6,x5,x0` forwards rs1 (`need_forward`=10).
